// File: rtl/mul_div_unit_pkg.sv
// Shared types and decode helpers for the iterative RV64M multiply/divide unit.
package mul_div_unit_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] word_t;
  typedef logic            u1;

  typedef enum logic [3:0] {
    MD_MUL    = 4'd0,
    MD_MULH   = 4'd1,
    MD_MULHSU = 4'd2,
    MD_MULHU  = 4'd3,
    MD_MULW   = 4'd4,
    MD_DIV    = 4'd5,
    MD_DIVU   = 4'd6,
    MD_REM    = 4'd7,
    MD_REMU   = 4'd8,
    MD_DIVW   = 4'd9,
    MD_DIVUW  = 4'd10,
    MD_REMW   = 4'd11,
    MD_REMUW  = 4'd12
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } md_state_t;

  // True for any encoding that names an M-extension operation.
  function automatic u1 is_mulalu(input logic [3:0] code);
    return code <= 4'd12;
  endfunction

  function automatic u1 is_div(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
  endfunction

  function automatic u1 is_rem(input md_op_t op);
    return op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
  endfunction

  function automatic u1 is_word(input md_op_t op);
    return op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
  endfunction

  // Operand signedness: MULHSU treats only rs1 as signed.
  function automatic u1 signed_a(input md_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULW, MD_DIV, MD_REM, MD_DIVW, MD_REMW};
  endfunction

  function automatic u1 signed_b(input md_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULW, MD_DIV, MD_REM, MD_DIVW, MD_REMW};
  endfunction

  function automatic word_t sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response interface between execute (master) and the multiply/divide unit (slave).
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic   valid;
  md_op_t op;
  word_t  src_a;
  word_t  src_b;
  logic   flush;
  logic   busy;
  logic   finish;
  word_t  result;

  modport master (output valid, op, src_a, src_b, flush, input busy, finish, result);
  modport slave  (input valid, op, src_a, src_b, flush, output busy, finish, result);
endinterface

// File: rtl/mul_div_unit_special.sv
// Detects divide-by-zero and signed overflow and produces the bypass result.
module md_special
  import mul_div_unit_pkg::*;
(
  input  md_op_t op,
  input  word_t  a_ext,
  input  word_t  b_ext,
  output u1      special,
  output word_t  result
);

  word_t min_val;

  // Classify the request and pick the architectural result for the corner cases.
  always_comb begin
    special = 1'b0;
    result  = '0;
    min_val = is_word(op) ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    if (is_div(op)) begin
      if (b_ext == '0) begin
        special = 1'b1;
        result  = is_rem(op) ? (is_word(op) ? sext32(a_ext[31:0]) : a_ext) : '1;
      end else if (signed_b(op) && a_ext == min_val && b_ext == '1) begin
        special = 1'b1;
        result  = is_rem(op) ? '0 : min_val;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter bit MUL_EARLY_OUT = 1'b0
) (
  input  logic          clk,
  input  logic          resetn,
  mul_div_unit_if.slave md
);

  md_state_t state, state_next;

  md_op_t            op_q;
  u1                 neg_a_q, neg_b_q;
  logic [5:0]        count;
  logic [2*XLEN-1:0] prod, mcand;
  word_t             mplier, quo, rem, divisor, result_q;

  u1     word_op, neg_a, neg_b, accept, special, run_done, div_ge;
  word_t a_ext, b_ext, mag_a, mag_b, special_result, rem_step, quo_fix, rem_fix, fix_result;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;

  // Word-extend the incoming operands and take magnitudes so the core iterates unsigned.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    word_op = is_word(md.op);
    a_ext   = md.src_a;
    b_ext   = md.src_b;
    if (word_op) begin
      a_ext = signed_a(md.op) ? sext32(md.src_a[31:0]) : {32'b0, md.src_a[31:0]};
      b_ext = signed_b(md.op) ? sext32(md.src_b[31:0]) : {32'b0, md.src_b[31:0]};
    end
    neg_a = signed_a(md.op) && a_ext[XLEN-1];
    neg_b = signed_b(md.op) && b_ext[XLEN-1];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
  end

  md_special u_special (
    .op      (md.op),
    .a_ext   (a_ext),
    .b_ext   (b_ext),
    .special (special),
    .result  (special_result)
  );

  assign accept = (state == ST_IDLE) && md.valid && !md.flush;

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, divisor};
    div_ge    = !div_diff[XLEN];
    rem_step  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  end

  // Last iteration reached, or (optionally) no multiplier bits left to add.
  always_comb begin
    run_done = (count == '0) ||
               (MUL_EARLY_OUT && !is_div(op_q) && mplier[XLEN-1:1] == '0);
  end

  // Sign correction, word truncation and sign extension of the raw core outputs.
  always_comb begin
    prod_fix   = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_fix    = (neg_a_q ^ neg_b_q) ? -quo  : quo;
    rem_fix    = neg_a_q ? -rem : rem;
    fix_result = '0;
    case (op_q)
      MD_MUL:                        fix_result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
      MD_MULW:                       fix_result = sext32(prod_fix[31:0]);
      MD_DIV, MD_DIVU:               fix_result = quo_fix;
      MD_REM, MD_REMU:               fix_result = rem_fix;
      MD_DIVW, MD_DIVUW:             fix_result = sext32(quo_fix[31:0]);
      MD_REMW, MD_REMUW:             fix_result = sext32(rem_fix[31:0]);
      default:                       fix_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_next = state;
    if (md.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (md.valid) state_next = special ? ST_DONE : ST_RUN;
        ST_RUN:  if (run_done) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state.
  always_comb begin
    md.busy   = (state != ST_IDLE);
    md.finish = (state == ST_DONE) && !md.flush;
  end

  assign md.result = result_q;

  // Operand latch, per-cycle iteration and result write-back.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the iteration registers are reset too, so a reset mid-operation leaves no stale state.
      op_q     <= MD_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      count    <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= md.op;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      count   <= word_op ? 6'd31 : 6'd63;
      prod    <= '0;
      mcand   <= {{XLEN{1'b0}}, mag_a};
      mplier  <= mag_b;
      quo     <= word_op ? {mag_a[31:0], 32'b0} : mag_a;
      rem     <= '0;
      divisor <= mag_b;
      if (special) result_q <= special_result;
    end else if (state == ST_RUN && !md.flush) begin
      count <= count - 6'd1;
      if (is_div(op_q)) begin
        quo <= {quo[XLEN-2:0], div_ge};
        rem <= rem_step;
      end else begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end else if (state == ST_FIX && !md.flush) begin
      result_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops vs a reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int TIMEOUT = 200;

  typedef struct {
    md_op_t op;
    word_t  a;
    word_t  b;
    word_t  exp;
    int     lat;
  } vec_t;

  logic  clk = 1'b0;
  logic  resetn;
  int    checks = 0;
  int    errors = 0;
  word_t held = '0;

  mul_div_unit_if md_bus ();

  mul_div_unit #(.MUL_EARLY_OUT(1'b0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .md     (md_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic word_t sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic bit ref_word(input md_op_t op);
    return op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
  endfunction

  function automatic bit ref_special(input md_op_t op, input word_t a, input word_t b);
    bit w;
    w = ref_word(op);
    if (!(op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW}))
      return 1'b0;
    if (w ? (b[31:0] == 32'h0) : (b == 64'h0)) return 1'b1;
    if (op inside {MD_DIV, MD_REM} && a == 64'h8000_0000_0000_0000 && b == '1) return 1'b1;
    if (op inside {MD_DIVW, MD_REMW} && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ref_latency(input md_op_t op, input word_t a, input word_t b);
    if (ref_special(op, a, b)) return 1;
    return ref_word(op) ? 34 : 66;
  endfunction

  function automatic word_t ref_result(input md_op_t op, input word_t a, input word_t b);
    logic signed [127:0] sa128, sb128, p;
    logic [127:0]        ua, ub, up;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  sa32, sb32;
    logic [31:0]         ua32, ub32;
    bit                  ovf64, ovf32;
    word_t               r;
    sa = a; sb = b; sa128 = sa; sb128 = sb;
    ua = {64'b0, a}; ub = {64'b0, b};
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    r = '0;
    case (op)
      MD_MUL:    begin up = ua * ub; r = up[63:0]; end
      MD_MULH:   begin p = sa128 * sb128; r = p[127:64]; end
      MD_MULHSU: begin p = sa128 * $signed(ub); r = p[127:64]; end
      MD_MULHU:  begin up = ua * ub; r = up[127:64]; end
      MD_MULW:   begin up = ua * ub; r = sx32(up[31:0]); end
      MD_DIV:    r = (b == 0) ? '1 : (ovf64 ? a : word_t'(sa / sb));
      MD_DIVU:   r = (b == 0) ? '1 : a / b;
      MD_REM:    r = (b == 0) ? a : (ovf64 ? '0 : word_t'(sa % sb));
      MD_REMU:   r = (b == 0) ? a : a % b;
      MD_DIVW:   r = (ub32 == 0) ? '1 : (ovf32 ? sx32(32'h8000_0000) : sx32(sa32 / sb32));
      MD_DIVUW:  r = (ub32 == 0) ? '1 : sx32(ua32 / ub32);
      MD_REMW:   r = (ub32 == 0) ? sx32(ua32) : (ovf32 ? '0 : sx32(sa32 % sb32));
      MD_REMUW:  r = (ub32 == 0) ? sx32(ua32) : sx32(ua32 % ub32);
      default:   r = '0;
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_req(input md_op_t op, input word_t a, input word_t b);
    md_bus.valid = 1'b1;
    md_bus.op    = op;
    md_bus.src_a = a;
    md_bus.src_b = b;
  endtask

  // Called right after the accept edge; lat is the cycle finish was seen in (TIMEOUT if never).
  task automatic wait_finish(output int lat, output bit busy_ok);
    lat     = TIMEOUT;
    busy_ok = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      @(negedge clk);
      if (md_bus.finish) begin
        lat = c;
        break;
      end
      if (!md_bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_and_check(input string name, input md_op_t op, input word_t a,
                               input word_t b, input word_t exp, input int exp_lat);
    int lat;
    bit busy_ok;
    @(negedge clk);
    drive_req(op, a, b);
    @(posedge clk);
    wait_finish(lat, busy_ok);
    md_bus.valid = 1'b0;
    checks++;
    if (md_bus.result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, md_bus.result, exp);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: got low before finish expected high", name);
    end
    held = exp;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn        = 1'b0;
    md_bus.valid  = 1'b0;
    md_bus.flush  = 1'b0;
    md_bus.op     = MD_MUL;
    md_bus.src_a  = '0;
    md_bus.src_b  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (md_bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", md_bus.busy); end
    checks++;
    if (md_bus.finish !== 1'b0) begin errors++; $display("FAIL reset finish: got %b expected 0", md_bus.finish); end
    checks++;
    if (md_bus.result !== '0) begin errors++; $display("FAIL reset result: got %h expected 0", md_bus.result); end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (md_bus.busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b expected 0", md_bus.busy); end
  endtask

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{MD_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66});
    v.push_back('{MD_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66});
    v.push_back('{MD_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    v.push_back('{MD_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66});
    v.push_back('{MD_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    v.push_back('{MD_DIVUW,  64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34});
    v.push_back('{MD_DIV,    64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    v.push_back('{MD_REMU,   64'd5, 64'd0, 64'd5, 1});
    v.push_back('{MD_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
    v.push_back('{MD_REM,    64'h8000_0000_0000_0000, '1, 64'd0, 1});
    foreach (v[i])
      run_and_check($sformatf("dir%0d_%s", i, v[i].op.name()), v[i].op, v[i].a, v[i].b,
                    v[i].exp, v[i].lat);
  endtask

  task automatic test_random();
    logic [3:0] code;
    md_op_t     op;
    word_t      a, b;
    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 12));
      op   = md_op_t'(code);
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        1: begin
          a = a >> $urandom_range(0, 63);
          b = b >> $urandom_range(40, 63);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        2: b = ($urandom_range(0, 1) == 1) ? '0 : {b[63:32], 32'h0};
        3: begin
          if (ref_word(op)) begin
            a = {a[63:32], 32'h8000_0000};
            b = {b[63:32], 32'hFFFF_FFFF};
          end else begin
            a = 64'h8000_0000_0000_0000;
            b = '1;
          end
        end
        default: ;
      endcase
      run_and_check($sformatf("rnd%0d_%s", i, op.name()), op, a, b, ref_result(op, a, b),
                    ref_latency(op, a, b));
    end
  endtask

  task automatic test_flush();
    int lat;
    bit busy_ok;
    @(negedge clk);
    drive_req(MD_MUL, 64'd3, 64'd5);
    @(posedge clk);
    repeat (10) @(negedge clk);
    md_bus.flush = 1'b1;
    @(negedge clk);
    md_bus.flush = 1'b0;
    checks++;
    if (md_bus.busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b expected 0", md_bus.busy); end
    checks++;
    if (md_bus.finish !== 1'b0) begin errors++; $display("FAIL flush finish: got %b expected 0", md_bus.finish); end
    checks++;
    if (md_bus.result !== held) begin errors++; $display("FAIL flush result: got %h expected %h", md_bus.result, held); end
    // New request presented in the very next cycle must be accepted.
    drive_req(MD_DIVU, 64'd100, 64'd7);
    @(posedge clk);
    wait_finish(lat, busy_ok);
    md_bus.valid = 1'b0;
    checks++;
    if (md_bus.result !== 64'd14) begin errors++; $display("FAIL post_flush result: got %h expected %h", md_bus.result, 64'd14); end
    checks++;
    if (lat !== 66) begin errors++; $display("FAIL post_flush latency: got %0d expected 66", lat); end
    held = 64'd14;
    // flush together with valid in IDLE: request is dropped.
    @(negedge clk);
    drive_req(MD_DIV, 64'd9, 64'd3);
    md_bus.flush = 1'b1;
    @(negedge clk);
    md_bus.flush = 1'b0;
    md_bus.valid = 1'b0;
    checks++;
    if (md_bus.busy !== 1'b0) begin errors++; $display("FAIL flush_valid busy: got %b expected 0", md_bus.busy); end
    @(negedge clk);
    checks++;
    if (md_bus.finish !== 1'b0) begin errors++; $display("FAIL flush_valid finish: got %b expected 0", md_bus.finish); end
    checks++;
    if (md_bus.result !== held) begin errors++; $display("FAIL flush_valid result: got %h expected %h", md_bus.result, held); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    drive_req(MD_MUL, 64'd11, 64'd13);
    @(posedge clk);
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (md_bus.busy !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", md_bus.busy); end
    checks++;
    if (md_bus.finish !== 1'b0) begin errors++; $display("FAIL midrst finish: got %b expected 0", md_bus.finish); end
    checks++;
    if (md_bus.result !== '0) begin errors++; $display("FAIL midrst result: got %h expected 0", md_bus.result); end
    md_bus.valid = 1'b0;
    held = '0;
    @(negedge clk);
    resetn = 1'b1;
    run_and_check("midrst_mulw", MD_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
  endtask

  task automatic test_back_to_back();
    int    lat;
    bit    busy_ok;
    word_t exp2;
    @(negedge clk);
    drive_req(MD_DIVU, 64'd1000, 64'd10);
    @(posedge clk);
    wait_finish(lat, busy_ok);
    checks++;
    if (md_bus.result !== 64'd100) begin errors++; $display("FAIL b2b_first result: got %h expected %h", md_bus.result, 64'd100); end
    // Next request presented during DONE: ignored there, accepted one cycle later.
    drive_req(MD_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3);
    exp2 = ref_result(MD_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3);
    @(negedge clk);
    checks++;
    if (md_bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_gap busy: got %b expected 0", md_bus.busy); end
    @(posedge clk);
    wait_finish(lat, busy_ok);
    md_bus.valid = 1'b0;
    checks++;
    if (md_bus.result !== exp2) begin errors++; $display("FAIL b2b_second result: got %h expected %h", md_bus.result, exp2); end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL b2b_second latency: got %0d expected 34", lat); end
    held = exp2;
    @(negedge clk);
    checks++;
    if (md_bus.result !== held) begin errors++; $display("FAIL b2b_hold result: got %h expected %h", md_bus.result, held); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
